// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared encodings for the AXI read slave: burst types, response codes, the
// 32-byte beat width, the read FSM state type and the burst legality check.
// -----------------------------------------------------------------------------
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int BEAT_BYTES = 32;
   localparam int BEAT_LSB   = $clog2(BEAT_BYTES);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } rd_state_t;

   // A burst is answered with SLVERR on every beat when the beat is wider
   // than the memory word, the burst type is reserved, or a WRAP length is
   // not 2/4/8/16 beats.
   function automatic logic burst_err(input logic [2:0] size,
                                      input logic [7:0] len,
                                      input logic [1:0] burst);
      logic bad_wrap;
      bad_wrap = (burst == BURST_WRAP) &&
                 !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
      return (size > 3'(BEAT_LSB)) || (burst == BURST_RSVD) || bad_wrap;
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// -----------------------------------------------------------------------------
// axi_burst_addr
// Combinational next-beat address for an AXI burst.
//   i_addr  [31:0] current beat address (first beat may be unaligned)
//   i_size  [2:0]  log2 bytes per beat
//   i_len   [7:0]  beats minus one
//   i_burst [1:0]  FIXED / INCR / WRAP / reserved
//   o_next  [31:0] address of the following beat
// -----------------------------------------------------------------------------
module axi_burst_addr
   import axi_pkg::*;
(
   input  logic [31:0] i_addr,
   input  logic [2:0]  i_size,
   input  logic [7:0]  i_len,
   input  logic [1:0]  i_burst,
   output logic [31:0] o_next
);

   logic [31:0] w_incr;
   logic [31:0] w_bound;

   assign w_incr  = 32'd1 << i_size;
   assign w_bound = ({24'd0, i_len} + 32'd1) << i_size;

   always_comb begin
      o_next = i_addr;
      case (i_burst)
         BURST_INCR: o_next = (i_addr & ~(w_incr - 32'd1)) + w_incr;
         // Wrap keeps the upper bits of the boundary-aligned block and lets
         // only the offset inside the block roll over.
         BURST_WRAP: o_next = (i_addr & ~(w_bound - 32'd1)) |
                              ((i_addr + w_incr) & (w_bound - 32'd1));
         default:    o_next = i_addr;
      endcase
   end

endmodule

// File: rtl/axi_read_slave.sv
// -----------------------------------------------------------------------------
// axi_read_slave
// Single-outstanding AXI read slave backed by a DEPTH x 256-bit memory that
// is filled through a side preload port.
//   i_clk, i_reset           clock, async active-high reset
//   arid/araddr/arlen/arsize/arburst/arvalid -> arready   read address channel
//   rid/rdata/rresp/rlast/rvalid <- rready                 read data channel
//   pl_we/pl_addr/pl_wdata   memory preload (any state, not cleared by reset)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for an AR handshake, arready high (once out of reset)
// ST_DATA | presenting beats, rvalid high, advance on rready
// -----------------------------------------------------------------------------
module axi_read_slave
   import axi_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int ID_W  = 7
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [ID_W-1:0]          arid,
   input  logic [31:0]              araddr,
   input  logic [7:0]               arlen,
   input  logic [2:0]               arsize,
   input  logic [1:0]               arburst,
   input  logic                     arvalid,
   output logic                     arready,
   output logic [ID_W-1:0]          rid,
   output logic [255:0]             rdata,
   output logic [1:0]               rresp,
   output logic                     rlast,
   output logic                     rvalid,
   input  logic                     rready,
   input  logic                     pl_we,
   input  logic [$clog2(DEPTH)-1:0] pl_addr,
   input  logic [255:0]             pl_wdata
);

   localparam int AW = $clog2(DEPTH);

   rd_state_t       r_state;
   rd_state_t       w_state_nxt;
   logic            r_ar_en;
   logic [ID_W-1:0] r_id;
   logic [31:0]     r_addr;
   logic [7:0]      r_len;
   logic [2:0]      r_size;
   logic [1:0]      r_burst;
   logic [7:0]      r_cnt;
   logic            r_err;
   logic [255:0]    r_mem [DEPTH];

   logic            w_ar_hs;
   logic            w_r_hs;
   logic            w_last;
   logic [31:0]     w_next_addr;

   assign w_ar_hs = arvalid && arready;
   assign w_r_hs  = rvalid && rready;
   assign w_last  = (r_cnt == r_len);

   axi_burst_addr u_burst_addr (
      .i_addr  (r_addr),
      .i_size  (r_size),
      .i_len   (r_len),
      .i_burst (r_burst),
      .o_next  (w_next_addr)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Holds arready low while reset is asserted; it rises on the first edge
   // after release.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_ar_en <= 1'b0;
      else         r_ar_en <= 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      arready     = 1'b0;
      rvalid      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            arready = r_ar_en;
            if (arvalid && r_ar_en) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            rvalid = 1'b1;
            if (rready && w_last) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else if (w_ar_hs) begin
         r_id    <= arid;
         r_addr  <= araddr;
         r_len   <= arlen;
         r_size  <= arsize;
         r_burst <= arburst;
         r_cnt   <= '0;
         r_err   <= burst_err(arsize, arlen, arburst);
      end else if (w_r_hs && !w_last) begin
         r_addr  <= w_next_addr;
         r_cnt   <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (pl_we) r_mem[pl_addr] <= pl_wdata;
   end

   // Read is asynchronous from the current beat address, so a preload to the
   // presented word shows up the cycle after the write edge.
   assign rdata = r_mem[r_addr[BEAT_LSB +: AW]];
   assign rid   = r_id;
   assign rlast = rvalid && w_last;
   assign rresp = (rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
REQ-001 Parameter DEPTH, default 16, meaning number of 256-bit memory words (power of two, 2..256).
REQ-002 Parameter ID_W, default 7, meaning AXI ID width.
REQ-003 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 arid  input  ID_W  read address ID.
REQ-006 araddr  input  32  byte address of first beat.
REQ-007 arlen  input  8  beats minus one.
REQ-008 arsize  input  3  log2 bytes per beat.
REQ-009 arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-010 arvalid / arready  input / output  1 / 1  AR handshake.
REQ-011 rid  output  ID_W  echo of accepted arid.
REQ-012 rdata  output  256  memory word of current beat.
REQ-013 rresp  output  2  00 OKAY, 10 SLVERR.
REQ-014 rlast / rvalid  output  1 / 1  last beat, data valid.
REQ-015 rready  input  1  master accepts beat.
REQ-016 pl_we  input  1  preload write enable.
REQ-017 pl_addr  input  log2(DEPTH)  preload word index.
REQ-018 pl_wdata  input  256  preload data.

Function
REQ-019 The FSM SHALL have two states: IDLE (arready=1, rvalid=0) and DATA (arready=0, rvalid=1).
REQ-020 IDLE->DATA on arvalid&&arready: latch arid, araddr, arlen, arsize, arburst, zero beat counter; rvalid SHALL rise the cycle after acceptance.
REQ-021 Only one burst SHALL be outstanding; arready SHALL first reassert the cycle after the last-beat handshake.
REQ-022 Word index SHALL be cur_addr[5 +: log2(DEPTH)] (modulo DEPTH); rdata SHALL equal mem[index] of the current beat address.
REQ-023 The first beat SHALL use araddr unaligned; INCR next = (cur_addr & ~(2^arsize-1)) + 2^arsize, 32-bit wrap-around.
REQ-024 FIXED SHALL keep cur_addr constant for all beats.
REQ-025 WRAP boundary B = (arlen+1)*2^arsize; next = (cur_addr & ~(B-1)) | ((cur_addr + 2^arsize) & (B-1)).
REQ-026 Beat advances only on rvalid&&rready; rdata, rid, rresp, rlast SHALL be held stable while rvalid&&!rready.
REQ-027 rlast SHALL be 1 exactly when beat counter == latched arlen; the handshake on that beat SHALL return the FSM to IDLE.
REQ-028 rresp SHALL be SLVERR for every beat when arsize>5, arburst==11, or WRAP with arlen not in {1,3,7,15}; otherwise OKAY; beat count SHALL still be arlen+1.
REQ-029 pl_we SHALL write mem[pl_addr] at the clock edge in any state; a write to the word currently presented SHALL change rdata from the next cycle.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-031 While i_reset=1: FSM=IDLE, arready=0, rvalid=0, rlast=0, rresp=00, rid=0; rdata is don't-care.
REQ-032 arready SHALL go to 1 on the first rising edge after i_reset deasserts.
REQ-033 Reset asserted mid-burst SHALL drop rvalid immediately (asynchronously) and discard the burst.

Structure
REQ-034 Package axi_pkg SHALL hold burst encodings (FIXED/INCR/WRAP), response encodings (OKAY/SLVERR) and the 32-byte beat width constant.
REQ-035 Next-address arithmetic (REQ-023..025) SHALL be a combinational sub-module axi_burst_addr (inputs addr, size, len, burst; output next addr).

Verification
REQ-036 Preload word0 = {128'h0, 128'hDEADBEEF_CAFEBABE_12345678_ABCDEF01}; AR 0x0, len0, size5, INCR -> one beat, rdata[127:0] matches, rlast=1, rresp=00, rid=arid.
REQ-037 Preload words0..3 = 0x11..,0x22..,0x33..,0x44..; AR 0x10, len3, size5, INCR -> words 0,1,2,3 in order, rlast only on beat 3.
REQ-038 AR 0x40, len3, size5, WRAP -> words 2,3,0,1; AR 0x40, len2, WRAP -> 3 beats, all SLVERR.
REQ-039 4-beat INCR with rready low 3 cycles after beat 1 -> rdata/rlast unchanged during stall, no beat lost or duplicated.
REQ-040 Assert i_reset during beat 2 of 4 -> rvalid=0 at once, arready=1 the first edge after release, next AR 0x0 len0 returns word0 OKAY.
REQ-041 Two back-to-back ARs with arvalid held high -> second accepted only the cycle after first rlast handshake, rid tracks each arid.
